// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// Optional forwarding outputs are enabled with the EX_MEM_FWD_EN macro.
module ex_mem_skid_stage #(
    parameter int DATA_W          = 32,
    parameter int REG_ADDR_W      = 5,
    parameter int FWD_DEPTH_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  iRegWrite,
    input  logic                  iMemToReg,
    input  logic                  iMemWrite,
    input  logic                  iMemRead,
    input  logic                  iMemBranch,
    input  logic                  ijump,
    input  logic [DATA_W-1:0]     iAdderSL2Result,
    input  logic                  iZFlag,
    input  logic [DATA_W-1:0]     iAluRes,
    input  logic [DATA_W-1:0]     iData2,
    input  logic [REG_ADDR_W-1:0] iRegDestMux,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  oRegWrite,
    output logic                  oMemToReg,
    output logic                  oMemWrite,
    output logic                  oMemRead,
    output logic                  oMemBranch,
    output logic                  ojump,
    output logic [DATA_W-1:0]     oAdderSL2Result,
    output logic                  oZFlag,
    output logic [DATA_W-1:0]     oAluRes,
    output logic [DATA_W-1:0]     oData2,
    output logic [REG_ADDR_W-1:0] oRegDestMux
`ifdef EX_MEM_FWD_EN
    ,
    output logic                  fwd_reg_write,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  mem_read;
        logic                  mem_branch;
        logic                  jump;
        logic [DATA_W-1:0]     target;
        logic                  zero;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     data2;
        logic [REG_ADDR_W-1:0] rd;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    beat_t  out_q;
    beat_t  skd_q;
    beat_t  in_beat;
    logic   acc;
    logic   pop;
    logic   load_in;
    logic   load_skd;
    logic   move_skd;
    logic   gate;

    assign in_beat = {iRegWrite, iMemToReg, iMemWrite, iMemRead,
                      iMemBranch, ijump, iAdderSL2Result, iZFlag,
                      iAluRes, iData2, iRegDestMux};

    // Ready is decoded from the state flop only, so it never depends on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        load_in  = 1'b0;
        load_skd = 1'b0;
        move_skd = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        load_in  = 1'b1;
                        state_nx = BUSY;
                    end
                end
                BUSY: begin
                    if (acc && pop) begin
                        load_in = 1'b1;
                    end else if (acc) begin
                        load_skd = 1'b1;
                        state_nx = FULL;
                    end else if (pop) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        move_skd = 1'b1;
                        state_nx = BUSY;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Bubbles must not carry side-effecting control into MEM.
    assign gate = (state_nx == EMPTY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            out_q <= '0;
            skd_q <= '0;
        end else begin
            state <= state_nx;
            if (load_in) begin
                out_q <= in_beat;
            end else if (move_skd) begin
                out_q <= skd_q;
            end else if (gate) begin
                out_q.reg_write  <= 1'b0;
                out_q.mem_write  <= 1'b0;
                out_q.mem_read   <= 1'b0;
                out_q.mem_branch <= 1'b0;
                out_q.jump       <= 1'b0;
            end
            if (load_skd) begin
                skd_q <= in_beat;
            end
        end
    end

    assign oRegWrite       = out_q.reg_write;
    assign oMemToReg       = out_q.mem_to_reg;
    assign oMemWrite       = out_q.mem_write;
    assign oMemRead        = out_q.mem_read;
    assign oMemBranch      = out_q.mem_branch;
    assign ojump           = out_q.jump;
    assign oAdderSL2Result = out_q.target;
    assign oZFlag          = out_q.zero;
    assign oAluRes         = out_q.alu;
    assign oData2          = out_q.data2;
    assign oRegDestMux     = out_q.rd;

`ifdef EX_MEM_FWD_EN
    logic fwd_qual;

    assign fwd_qual      = (FWD_DEPTH_CHECK != 0) ? out_valid : 1'b1;
    assign fwd_reg_write = out_q.reg_write & ~out_q.mem_to_reg & fwd_qual;
    assign fwd_rd        = out_q.rd;
    assign fwd_data      = out_q.alu;
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed table plus random
// traffic against a queue-based reference model.
module tb_ex_mem_skid_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        mr;
        logic        mb;
        logic        j;
        logic [31:0] tgt;
        logic        z;
        logic [31:0] alu;
        logic [31:0] d2;
        logic [4:0]  rd;
    } beat_t;

    typedef struct {
        bit          iv;
        bit          ordy;
        bit          fl;
        logic [31:0] alu;
        bit          ev;
        bit          er;
        logic [31:0] ea;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    beat_t       din;
    beat_t       dout;
    logic        oRegWrite, oMemToReg, oMemWrite, oMemRead, oMemBranch, ojump;
    logic [31:0] oAdderSL2Result, oAluRes, oData2;
    logic        oZFlag;
    logic [4:0]  oRegDestMux;
`ifdef EX_MEM_FWD_EN
    logic        fwd_reg_write;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    ex_mem_skid_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .iRegWrite       (din.rw),
        .iMemToReg       (din.m2r),
        .iMemWrite       (din.mw),
        .iMemRead        (din.mr),
        .iMemBranch      (din.mb),
        .ijump           (din.j),
        .iAdderSL2Result (din.tgt),
        .iZFlag          (din.z),
        .iAluRes         (din.alu),
        .iData2          (din.d2),
        .iRegDestMux     (din.rd),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .oRegWrite       (oRegWrite),
        .oMemToReg       (oMemToReg),
        .oMemWrite       (oMemWrite),
        .oMemRead        (oMemRead),
        .oMemBranch      (oMemBranch),
        .ojump           (ojump),
        .oAdderSL2Result (oAdderSL2Result),
        .oZFlag          (oZFlag),
        .oAluRes         (oAluRes),
        .oData2          (oData2),
        .oRegDestMux     (oRegDestMux)
`ifdef EX_MEM_FWD_EN
        ,
        .fwd_reg_write   (fwd_reg_write),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data)
`endif
    );

    assign dout = {oRegWrite, oMemToReg, oMemWrite, oMemRead, oMemBranch,
                   ojump, oAdderSL2Result, oZFlag, oAluRes, oData2,
                   oRegDestMux};

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t q[$];
    beat_t shown;
    bit    m_ready = 1'b1;
    vec_t  tbl[16];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t gated(input beat_t b);
        beat_t r;
        r    = b;
        r.rw = 1'b0;
        r.mw = 1'b0;
        r.mr = 1'b0;
        r.mb = 1'b0;
        r.j  = 1'b0;
        return r;
    endfunction

    function automatic beat_t mk(input logic [31:0] a);
        beat_t b;
        b     = '0;
        b.rw  = 1'b1;
        b.mw  = 1'b1;
        b.alu = a;
        b.d2  = ~a;
        b.tgt = a + 32'd4;
        b.rd  = a[4:0];
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[$bits(beat_t)-1:0];
    endfunction

    // One clock: drive, advance, update the FIFO-style model, compare.
    task automatic step(input bit rst, input bit fl, input bit iv,
                        input bit ordy, input beat_t b);
        bit acc;
        bit pop;
        rst_n     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        din       = b;
        acc = iv && m_ready;
        pop = ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            shown = '0;
        end else begin
            if (fl) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
            shown = (q.size() > 0) ? q[0] : gated(shown);
        end
        m_ready = (q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, m_ready);
        chk("payload", dout, shown);
`ifdef EX_MEM_FWD_EN
        chk("fwd_reg_write", fwd_reg_write,
            shown.rw & ~shown.m2r & (q.size() > 0));
        chk("fwd_rd", fwd_rd, shown.rd);
        chk("fwd_data", fwd_data, shown.alu);
`endif
    endtask

    initial begin
        beat_t b;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;

        tbl[0]  = '{1, 1, 0, 32'h10, 1, 1, 32'h10};
        tbl[1]  = '{1, 1, 0, 32'h20, 1, 1, 32'h20};
        tbl[2]  = '{1, 1, 0, 32'h30, 1, 1, 32'h30};
        tbl[3]  = '{1, 1, 0, 32'h40, 1, 1, 32'h40};
        tbl[4]  = '{0, 1, 0, 32'h99, 0, 1, 32'h40};
        tbl[5]  = '{1, 0, 0, 32'hA,  1, 1, 32'hA};
        tbl[6]  = '{1, 0, 0, 32'hB,  1, 0, 32'hA};
        tbl[7]  = '{1, 0, 0, 32'hC,  1, 0, 32'hA};
        tbl[8]  = '{1, 1, 0, 32'hC,  1, 1, 32'hB};
        tbl[9]  = '{1, 1, 0, 32'hC,  1, 1, 32'hC};
        tbl[10] = '{0, 1, 0, 32'h99, 0, 1, 32'hC};
        tbl[11] = '{1, 0, 0, 32'h55, 1, 1, 32'h55};
        tbl[12] = '{1, 1, 0, 32'h66, 1, 1, 32'h66};
        tbl[13] = '{1, 0, 0, 32'h77, 1, 0, 32'h66};
        tbl[14] = '{1, 0, 1, 32'h88, 0, 1, 32'h66};
        tbl[15] = '{0, 0, 0, 32'h99, 0, 1, 32'h66};

        step(0, 0, 1, 0, mk(32'h10));
        step(0, 0, 1, 0, mk(32'h10));
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_outs", dout, 128'd0);

        for (int i = 0; i < 16; i++) begin
            step(1, tbl[i].fl, tbl[i].iv, tbl[i].ordy, mk(tbl[i].alu));
            chk("tbl_valid", out_valid, tbl[i].ev);
            chk("tbl_ready", in_ready, tbl[i].er);
            chk("tbl_alu", oAluRes, tbl[i].ea);
            chk("tbl_regwrite", oRegWrite, tbl[i].ev);
            chk("tbl_memwrite", oMemWrite, tbl[i].ev);
        end

`ifdef EX_MEM_FWD_EN
        b      = '0;
        b.rw   = 1'b1;
        b.rd   = 5'd7;
        b.alu  = 32'h1234;
        step(1, 0, 1, 0, b);
        chk("fwd_hit_we", fwd_reg_write, 1'b1);
        chk("fwd_hit_rd", fwd_rd, 5'd7);
        chk("fwd_hit_data", fwd_data, 32'h1234);
        b.m2r  = 1'b1;
        step(1, 0, 1, 1, b);
        chk("fwd_load_we", fwd_reg_write, 1'b0);
        step(1, 0, 0, 1, b);
        chk("fwd_empty_we", fwd_reg_write, 1'b0);
`else
        b = '0;
`endif

        for (int i = 0; i < 3000; i++) begin
            b = rnd_beat();
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- Parametrised EX→MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Sits between the execute stage (ALU, branch adder) and the memory stage.
- Adds over the plain EX/MEM register: back-pressure from MEM (cache or multi-cycle memory stall), flush for branch/jump squash, bubble tracking, configurable widths.
- Full throughput, 1 beat/cycle; in_ready is registered (no combinational ready path).

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- REG_ADDR_W, 5, width of destination register index.
- FWD_DEPTH_CHECK, 1, 1 = forwarding outputs qualified by out_valid; 0 = raw register contents. Only used with EX_MEM_FWD_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  squash all held beats and the incoming beat this cycle
- in_valid  in  1  EX beat present
- in_ready  out  1  stage can accept a beat (registered)
- iRegWrite, iMemToReg, iMemWrite, iMemRead, iMemBranch, ijump  in  1 each  control bundle
- iAdderSL2Result  in  DATA_W  branch target
- iZFlag  in  1  ALU zero flag
- iAluRes  in  DATA_W  ALU result / address
- iData2  in  DATA_W  store data
- iRegDestMux  in  REG_ADDR_W  destination register
- out_valid  out  1  MEM beat present
- out_ready  in  1  MEM consumes beat
- oRegWrite, oMemToReg, oMemWrite, oMemRead, oMemBranch, ojump  out  1 each  registered control
- oAdderSL2Result, oZFlag, oAluRes, oData2, oRegDestMux  out  as inputs  registered payload

Behaviour:
- Storage: output register OUT (drives all o* ports) and skid register SKD, each with a valid bit.
- States: EMPTY (OUT invalid), BUSY (OUT valid, SKD invalid), FULL (both valid). SKD is never valid while OUT is invalid.
- Handshakes: acc = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !SKD.valid, registered; out_valid = OUT.valid.
- EMPTY:
  - acc → load OUT → BUSY.
- BUSY:
  - acc & pop → load OUT, stay BUSY.
  - acc & !pop → load SKD → FULL.
  - !acc & pop → EMPTY.
  - else hold.
- FULL (in_ready=0, so no acc):
  - pop → move SKD to OUT → BUSY.
  - else hold.
- Latency: input to output 1 cycle when not back-pressured.
- Ordering: beats leave in arrival order; no duplication, no loss unless flushed.
- Flush (highest priority after reset):
  - Next state is EMPTY; both valids cleared.
  - The incoming beat in the flush cycle is discarded, even if acc.
  - in_ready is 1 in the next cycle.
  - A pop in the same cycle still completes; MEM saw the beat.
- Bubble gating: when OUT.valid=0, the registered oRegWrite, oMemWrite, oMemRead, oMemBranch and ojump are 0 (cleared on every transition to EMPTY).
  - Payload outputs hold their last value while invalid.
- Reset (rst_n=0 at a clock edge):
  - All valids 0, all o* outputs 0, in_ready=1.
  - Takes precedence over flush and handshakes.
  - Mid-operation reset drops held beats silently.
- out_valid, once raised, stays high with a stable payload until pop or flush.

Optional Feature:
- Macro EX_MEM_FWD_EN.
- Defined: adds outputs fwd_reg_write (1), fwd_rd (REG_ADDR_W), fwd_data (DATA_W), driven combinationally from OUT:
  - fwd_reg_write = oRegWrite & !oMemToReg, also ANDed with out_valid when FWD_DEPTH_CHECK=1.
  - fwd_rd = oRegDestMux, fwd_data = oAluRes.
  - Used by the EX forwarding unit.
- Undefined: ports absent; no extra logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, all o* = 0, in_ready=1; the first beat is accepted on the cycle after release.
- Streaming: out_ready=1, 4 beats with iAluRes=0x10,0x20,0x30,0x40 on consecutive cycles → same values appear on oAluRes on cycles +1..+4; in_ready stays 1.
- Back-pressure: out_ready=0, send A=0xA, B=0xB, C=0xC → OUT=A, SKD=B, in_ready=0 next cycle, C held by source. Raise out_ready → A, B, C delivered in order, no loss.
- Flush while FULL: state FULL, flush=1 with in_valid=1 (iRegWrite=1, iMemWrite=1) → next cycle out_valid=0, oRegWrite=0, oMemWrite=0, in_ready=1; the flushed input never appears.
- Simultaneous accept and pop in BUSY: OUT=0x55, out_ready=1, input 0x66 → next cycle oAluRes=0x66, state BUSY, SKD unused.
- EX_MEM_FWD_EN: OUT holds iRegWrite=1, iMemToReg=0, rd=7, AluRes=0x1234 → fwd_reg_write=1, fwd_rd=7, fwd_data=0x1234. With MemToReg=1, or out_valid=0 and FWD_DEPTH_CHECK=1 → fwd_reg_write=0.
